// File: rtl/mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// mem_ctrl : serializes LSB / instruction-fetch requests onto the byte-wide
//            RAM/IO bus, little-endian, one request at a time.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        lsb_en,
  input  logic        lsb_rw,
  input  logic [31:0] lsb_addr,
  input  logic [2:0]  lsb_len,
  input  logic [31:0] lsb_w_data,
  output logic        lsb_done,
  output logic [31:0] lsb_r_data,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic c_OWN_LSB = 1'b0;
  localparam logic c_OWN_IF  = 1'b1;

  state_t      r_state,      w_state_nxt;
  logic        r_owner,      w_owner_nxt;
  logic [31:0] r_base,       w_base_nxt;
  logic [2:0]  r_len,        w_len_nxt;
  logic [2:0]  r_cnt,        w_cnt_nxt;
  logic        r_io,         w_io_nxt;
  logic [31:0] r_buf,        w_buf_nxt;
  logic [31:0] r_mem_a,      w_mem_a_nxt;
  logic [7:0]  r_mem_dout,   w_mem_dout_nxt;
  logic        r_wr,         w_wr_nxt;
  logic        r_lsb_done,   w_lsb_done_nxt;
  logic        r_if_done,    w_if_done_nxt;
  logic [31:0] r_lsb_r_data, w_lsb_r_data_nxt;
  logic [31:0] r_if_data,    w_if_data_nxt;

  logic [2:0]  w_req_len;
  logic [2:0]  w_cnt_inc;
  logic [31:0] w_cur_a;
  logic [31:0] w_buf_cap;
  logic [7:0]  w_next_byte;
  logic        w_stall;

  assign w_req_len   = (lsb_len == 3'd1) ? 3'd1 :
                       (lsb_len == 3'd2) ? 3'd2 : 3'd4;
  assign w_cnt_inc   = r_cnt + 3'd1;
  assign w_cur_a     = r_base + {29'd0, r_cnt};
  assign w_next_byte = r_buf[{w_cnt_inc[1:0], 3'b000} +: 8];
  assign w_stall     = r_io & io_buffer_full;

  // RAM answers one cycle late, so the byte on mem_din belongs to slot cnt-1
  always_comb begin
    w_buf_cap = r_buf;
    case (r_cnt)
      3'd1:    w_buf_cap[7:0]   = mem_din;
      3'd2:    w_buf_cap[15:8]  = mem_din;
      3'd3:    w_buf_cap[23:16] = mem_din;
      3'd4:    w_buf_cap[31:24] = mem_din;
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_base_nxt       = r_base;
    w_len_nxt        = r_len;
    w_cnt_nxt        = r_cnt;
    w_io_nxt         = r_io;
    w_buf_nxt        = r_buf;
    w_mem_a_nxt      = r_mem_a;
    w_mem_dout_nxt   = r_mem_dout;
    w_wr_nxt         = r_wr;
    w_lsb_done_nxt   = 1'b0;
    w_if_done_nxt    = 1'b0;
    w_lsb_r_data_nxt = r_lsb_r_data;
    w_if_data_nxt    = r_if_data;

    case (r_state)
      S_IDLE: begin
        // The done cycle still sees the old request's en high; skip it.
        if (!rollback && !r_lsb_done && !r_if_done) begin
          if (lsb_en) begin
            w_owner_nxt = c_OWN_LSB;
            w_base_nxt  = lsb_addr;
            w_len_nxt   = w_req_len;
            w_cnt_nxt   = 3'd0;
            w_io_nxt    = (lsb_addr[17:16] == 2'b11);
            w_mem_a_nxt = lsb_addr;
            if (lsb_rw) begin
              w_state_nxt    = S_WRITE;
              w_buf_nxt      = lsb_w_data;
              w_mem_dout_nxt = lsb_w_data[7:0];
              w_wr_nxt       = 1'b1;
            end else begin
              w_state_nxt = S_READ;
              w_buf_nxt   = 32'd0;
            end
          end else if (if_en) begin
            w_owner_nxt = c_OWN_IF;
            w_base_nxt  = if_addr;
            w_len_nxt   = 3'd4;
            w_cnt_nxt   = 3'd0;
            w_io_nxt    = 1'b0;
            w_mem_a_nxt = if_addr;
            w_state_nxt = S_READ;
            w_buf_nxt   = 32'd0;
          end
        end
      end

      S_READ: begin
        if (rollback) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 3'd0;
          w_mem_a_nxt = 32'd0;
          w_buf_nxt   = 32'd0;
        end else begin
          if (r_cnt != 3'd0) begin
            w_buf_nxt = w_buf_cap;
          end
          if (r_cnt == r_len) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
            w_mem_a_nxt = 32'd0;
            if (r_owner == c_OWN_IF) begin
              w_if_done_nxt = 1'b1;
              w_if_data_nxt = w_buf_cap;
            end else begin
              w_lsb_done_nxt   = 1'b1;
              w_lsb_r_data_nxt = w_buf_cap;
            end
          end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_mem_a_nxt = (w_cnt_inc < r_len) ? (w_cur_a + 32'd1) : 32'd0;
          end
        end
      end

      S_WRITE: begin
        // Stores are committed: rollback has no effect here.
        if (!w_stall) begin
          if (w_cnt_inc == r_len) begin
            w_state_nxt    = S_IDLE;
            w_cnt_nxt      = 3'd0;
            w_wr_nxt       = 1'b0;
            w_mem_a_nxt    = 32'd0;
            w_mem_dout_nxt = 8'd0;
            w_lsb_done_nxt = 1'b1;
          end else begin
            w_cnt_nxt      = w_cnt_inc;
            w_mem_a_nxt    = w_cur_a + 32'd1;
            w_mem_dout_nxt = w_next_byte;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_wr_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_owner      <= c_OWN_LSB;
      r_base       <= 32'd0;
      r_len        <= 3'd0;
      r_cnt        <= 3'd0;
      r_io         <= 1'b0;
      r_buf        <= 32'd0;
      r_mem_a      <= 32'd0;
      r_mem_dout   <= 8'd0;
      r_wr         <= 1'b0;
      r_lsb_done   <= 1'b0;
      r_if_done    <= 1'b0;
      r_lsb_r_data <= 32'd0;
      r_if_data    <= 32'd0;
    end else if (rdy) begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_base       <= w_base_nxt;
      r_len        <= w_len_nxt;
      r_cnt        <= w_cnt_nxt;
      r_io         <= w_io_nxt;
      r_buf        <= w_buf_nxt;
      r_mem_a      <= w_mem_a_nxt;
      r_mem_dout   <= w_mem_dout_nxt;
      r_wr         <= w_wr_nxt;
      r_lsb_done   <= w_lsb_done_nxt;
      r_if_done    <= w_if_done_nxt;
      r_lsb_r_data <= w_lsb_r_data_nxt;
      r_if_data    <= w_if_data_nxt;
    end
  end

  assign lsb_done   = r_lsb_done;
  assign lsb_r_data = r_lsb_r_data;
  assign if_done    = r_if_done;
  assign if_data    = r_if_data;
  assign mem_a      = r_mem_a;
  assign mem_dout   = r_mem_dout;
  // A full UART buffer holds off an IO byte without leaving WRITE
  assign mem_wr     = r_wr & rdy & ~w_stall;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mem_ctrl : directed vector table plus hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        lsb_en, lsb_rw;
  logic [31:0] lsb_addr, lsb_w_data;
  logic [2:0]  lsb_len;
  logic        lsb_done;
  logic [31:0] lsb_r_data;
  logic        if_en;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_ctrl u_dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .lsb_en(lsb_en), .lsb_rw(lsb_rw), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data),
    .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // Byte RAM: read data returns the address of the previous cycle.
  logic [7:0] ram [0:262143];
  always @(posedge clk) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit [47:0]   name;
    bit          is_if;
    bit          rw;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    int          nbytes;
    int          full_lo, full_hi;
    int          rdy_lo, rdy_hi;
    int          rb_at;
    int          exp_done;
    int          exp_first_wr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  task automatic drive(input vec_t v, input int k);
    rdy            = !(k >= v.rdy_lo && k <= v.rdy_hi);
    io_buffer_full = (k >= v.full_lo && k <= v.full_hi);
    rollback       = (k == v.rb_at);
    if (k == v.rb_at && v.exp_done < 0) begin
      lsb_en = 1'b0;
      if_en  = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int done_cyc, other_done, first_wr, wcnt, wr_bad, a_bad, quiet_bad, last;
    logic [31:0] got;
    logic own, oth;
    string nm;
    done_cyc = -1; other_done = 0; first_wr = -1; wcnt = 0;
    wr_bad = 0; a_bad = 0; quiet_bad = 0; got = 32'd0;
    nm   = $sformatf("%s", v.name);
    last = (v.exp_done >= 0) ? v.exp_done + 3 : 12;
    @(negedge clk);
    drive(v, 0);
    if (v.is_if) begin
      if_en = 1'b1; if_addr = v.addr;
    end else begin
      lsb_en = 1'b1; lsb_rw = v.rw; lsb_addr = v.addr;
      lsb_len = v.len; lsb_w_data = v.wdata;
    end
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (done_cyc >= 0 && k == done_cyc + 1) begin
        lsb_en = 1'b0; if_en = 1'b0;
      end
      drive(v, k);
      #1;
      own = v.is_if ? if_done : lsb_done;
      oth = v.is_if ? lsb_done : if_done;
      if (oth) other_done++;
      if (own && done_cyc < 0) begin
        done_cyc = k;
        got = v.is_if ? if_data : lsb_r_data;
      end else if (own) begin
        quiet_bad++;
      end
      if (mem_wr) begin
        if (!v.rw || wcnt > 3 || mem_a !== v.addr + wcnt ||
            mem_dout !== v.wdata[8*wcnt +: 8]) wr_bad++;
        if (first_wr < 0) first_wr = k;
        wcnt++;
      end
      if (!v.rw && v.rdy_lo < 0 && k <= v.nbytes && (v.rb_at < 0 || k <= v.rb_at) &&
          mem_a !== v.addr + (k - 1)) a_bad++;
      if (done_cyc >= 0 && k > done_cyc && (mem_wr || (!v.rw && mem_a !== 32'd0)))
        quiet_bad++;
      if (v.exp_done < 0 && k > v.rb_at && (mem_wr || mem_a !== 32'd0))
        quiet_bad++;
    end
    @(negedge clk);
    lsb_en = 1'b0; if_en = 1'b0; rollback = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    check({nm, " done_cycle"}, done_cyc, v.exp_done);
    check({nm, " other_done"}, other_done, 0);
    check({nm, " quiet"}, quiet_bad, 0);
    if (!v.rw && v.exp_done >= 0) check({nm, " rdata"}, got, v.exp_data);
    if (!v.rw && v.rdy_lo < 0) check({nm, " addr_seq"}, a_bad, 0);
    if (v.rw) begin
      check({nm, " wr_count"}, wcnt, v.nbytes);
      check({nm, " wr_bytes"}, wr_bad, 0);
      check({nm, " first_wr"}, first_wr, v.exp_first_wr);
    end else begin
      check({nm, " no_write"}, wcnt, 0);
    end
  endtask

  initial begin
    int lc, ic, both, pulses;
    logic [31:0] ld, id;
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ram[32'h400] = 8'hEF; ram[32'h401] = 8'hBE; ram[32'h402] = 8'hAD; ram[32'h403] = 8'hDE;
    ram[32'h3FFFF] = 8'h5A; ram[0] = 8'hA5;

    //            name     if rw addr           len   wdata         n  fl fh  rl rh  rb  done 1stwr data
    vecs[0]  = '{"LW",     0, 0, 32'h00000100, 3'd4, 32'h0,        4, -1, -1, -1, -1, -1, 6, -1, 32'h44332211};
    vecs[1]  = '{"SH",     0, 1, 32'h000001FF, 3'd2, 32'hABCD1234, 2, -1, -1, -1, -1, -1, 3,  1, 32'h0};
    vecs[2]  = '{"LBU",    0, 0, 32'h00000200, 3'd1, 32'h0,        1, -1, -1, -1, -1, -1, 3, -1, 32'h00000012};
    vecs[3]  = '{"LHU",    0, 0, 32'h00000102, 3'd2, 32'h0,        2, -1, -1, -1, -1, -1, 4, -1, 32'h00004433};
    vecs[4]  = '{"LEN7",   0, 0, 32'h00000100, 3'd7, 32'h0,        4, -1, -1, -1, -1, -1, 6, -1, 32'h44332211};
    vecs[5]  = '{"WRAP",   0, 0, 32'hFFFFFFFF, 3'd2, 32'h0,        2, -1, -1, -1, -1, -1, 4, -1, 32'h0000A55A};
    vecs[6]  = '{"FETCH",  1, 0, 32'h00000400, 3'd4, 32'h0,        4, -1, -1, -1, -1, -1, 6, -1, 32'hDEADBEEF};
    vecs[7]  = '{"IFRB",   1, 0, 32'h00000400, 3'd4, 32'h0,        4, -1, -1, -1, -1,  3, -1, -1, 32'h0};
    vecs[8]  = '{"SWRB",   0, 1, 32'h00000300, 3'd4, 32'h87654321, 4, -1, -1, -1, -1,  2, 5,  1, 32'h0};
    vecs[9]  = '{"LW300",  0, 0, 32'h00000300, 3'd4, 32'h0,        4, -1, -1, -1, -1, -1, 6, -1, 32'h87654321};
    vecs[10] = '{"IOSB",   0, 1, 32'h00030000, 3'd1, 32'h00000041, 1,  1,  3, -1, -1, -1, 5,  4, 32'h0};
    vecs[11] = '{"RDY",    0, 0, 32'h00000100, 3'd4, 32'h0,        4, -1, -1,  1,  3, -1, 9, -1, 32'h44332211};

    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    lsb_en = 1'b0; lsb_rw = 1'b0; lsb_addr = 32'd0; lsb_len = 3'd0; lsb_w_data = 32'd0;
    if_en = 1'b0; if_addr = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("reset mem_a", mem_a, 32'd0);
    check("reset ctl", {21'd0, mem_dout, mem_wr, lsb_done, if_done}, 32'd0);
    check("reset lsb_r_data", lsb_r_data, 32'd0);
    check("reset if_data", if_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Arbitration: both requests together, LSB first, fetch the cycle after.
    lc = -1; ic = -1; both = 0; ld = 32'd0; id = 32'd0;
    @(negedge clk);
    lsb_en = 1'b1; lsb_rw = 1'b0; lsb_addr = 32'h100; lsb_len = 3'd4;
    if_en = 1'b1; if_addr = 32'h400;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (lc >= 0 && k == lc + 1) lsb_en = 1'b0;
      if (ic >= 0 && k == ic + 1) if_en = 1'b0;
      #1;
      if (lsb_done && if_done) both++;
      if (lsb_done && lc < 0) begin lc = k; ld = lsb_r_data; end
      if (if_done && ic < 0) begin ic = k; id = if_data; end
    end
    lsb_en = 1'b0; if_en = 1'b0;
    check("arb lsb_done_cycle", lc, 6);
    check("arb lsb_data", ld, 32'h44332211);
    check("arb if_done_cycle", ic, 13);
    check("arb if_data", id, 32'hDEADBEEF);
    check("arb both_done", both, 0);

    // Asynchronous reset in the middle of a word load.
    @(negedge clk);
    lsb_en = 1'b1; lsb_rw = 1'b0; lsb_addr = 32'h100; lsb_len = 3'd4;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst mem_a", mem_a, 32'd0);
    check("arst lsb_r_data", lsb_r_data, 32'd0);
    check("arst if_data", if_data, 32'd0);
    check("arst ctl", {29'd0, mem_wr, lsb_done, if_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1; lsb_en = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (lsb_done || if_done || mem_wr) pulses++;
    end
    check("arst no_done", pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller and responder end of the load/store-buffer memory request interface. It also serves the instruction-fetch request port. It accepts one word/half/byte request at a time and serializes it into little-endian byte accesses on the 8-bit external RAM/IO bus. It signals completion with a one-cycle done pulse carrying read data. It sits between the LSB/fetch unit and the top-level RAM ports.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rdy  in  1  global ready; low freezes the block
- rollback  in  1  pipeline flush
- lsb_en  in  1  LSB request valid; held high until lsb_done
- lsb_rw  in  1  0 = load, 1 = store
- lsb_addr  in  32  byte address
- lsb_len  in  3  byte count: 1, 2 or 4; any other value is treated as 4
- lsb_w_data  in  32  store data; byte 0 = bits 7:0
- lsb_done  out  1  one-cycle completion pulse
- lsb_r_data  out  32  load data, zero-extended above len; valid while lsb_done
- if_en  in  1  instruction fetch request; word read; held until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle completion pulse
- if_data  out  32  fetched word; valid while if_done
- mem_din  in  8  RAM read byte; returns mem_a of the previous cycle
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  UART output buffer full

## Operation
- FSM states: IDLE, READ, WRITE. Registers:
  - owner (LSB/IF)
  - base address
  - len
  - byte counter cnt (3 bits)
  - io flag (addr[17:16]==2'b11)
  - 32-bit data buffer
- IDLE, rollback low:
  - lsb_en has priority: go to WRITE if lsb_rw=1, else READ.
  - Otherwise, if if_en is high, go to READ with len=4 and owner=IF.
- IDLE, rollback high: no request is accepted.
- READ:
  - cnt counts 0..len.
  - For cnt<len, mem_a=base+cnt.
  - For cnt>=1, mem_din is written to buffer byte cnt-1.
  - After capturing byte len-1: pulse the owner's done, present the buffer on r_data/if_data, return to IDLE, set mem_a to 0.
- WRITE:
  - Issue byte k with mem_a=base+k, mem_dout=w_data byte k, mem_wr=1.
  - After byte len-1: drop mem_wr, pulse lsb_done, return to IDLE.
  - IO store (io flag set): byte k is issued only on an edge where io_buffer_full is low. Otherwise mem_wr=0 and cnt holds; the stall length is unbounded.
- Rollback during READ: abort to IDLE on that edge, with no done pulse, mem_a reset to 0, buffer discarded.
- Rollback during WRITE: ignored; the store is already committed and completes normally.
- Address arithmetic is 32-bit modulo 2^32. base+cnt wraps with no error.
- Unused upper bytes of lsb_r_data are 0. Sign extension is the requester's job.
- The requester deasserts en on the done edge, so en is low in the IDLE cycle after done. The controller must not re-accept a request during the done cycle.

## Timing
- Reset values (asynchronous, on rst low): state IDLE, cnt 0, mem_a 0, mem_dout 0, mem_wr 0, lsb_done 0, if_done 0, lsb_r_data 0, if_data 0, buffer 0.
- All outputs are registered. mem_wr is additionally ANDed with rdy.
- rdy low: every register holds. mem_a is unchanged, so the RAM re-returns the same byte and capture stays correct after rdy returns.
- Read latency, with request seen in IDLE at cycle 0:
  - mem_a=base from cycle 1.
  - Bytes arrive on mem_din in cycles 2..len+1.
  - done is high in cycle len+2: LW/fetch → cycle 6, LB → cycle 3.
- Write latency, with request at cycle 0:
  - Bytes are written in cycles 1..len.
  - done is high in cycle len+1 (SW → 5), plus one cycle per IO stall.
- Done pulses are exactly one cycle wide. lsb_done and if_done are never high together.
- Back-to-back: the earliest next acceptance is the cycle after done, which is cycle len+3 for reads.
- An IF request arriving while an LSB access runs waits. It is accepted on the first IDLE cycle where lsb_en is low.

## Test plan
- LW: RAM[0x100..0x103]=11 22 33 44, lsb_en, rw=0, addr=0x100, len=4 at cycle 0 → mem_a 0x100..0x103 in cycles 1-4; lsb_done in cycle 6 with lsb_r_data=0x44332211; if_done stays 0.
- SH then LBU: store 0xABCD1234, len=2 to 0x1FF → mem_wr high in cycles 1-2 writing 34 then 12; lsb_done in cycle 3. Following LBU of 0x200 → lsb_r_data=0x00000012.
- Arbitration: lsb_en and if_en both high at cycle 0 → LSB served first. The fetch is accepted the cycle after lsb_done and if_done fires 6 cycles later with the correct word.
- Rollback: assert rollback at cycle 3 of an IF read → no if_done, state IDLE, mem_a=0. Assert rollback at cycle 2 of an SW → all 4 bytes still written and lsb_done at cycle 5.
- IO stall: SB 0x41 to 0x30000 with io_buffer_full high for cycles 1-3 → mem_wr 0 in cycles 1-3; write at cycle 4; lsb_done at cycle 5.
- Reset/rdy:
  - Pull rst low mid-LW → outputs go to 0 immediately and no done pulse follows.
  - Hold rdy low for 3 cycles mid-LW → done is delayed by exactly 3 cycles, data is unchanged, and mem_wr stays 0.
